// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock-divider bank.
//   MIN_DIV     smallest divisor a channel will ever run with
//   DFLT_DIV    divisor loaded into every channel at reset (default)
//   DFLT_DIV_W  default divisor width
//   div_t       divisor word at the default width
//   ch_mode_e   per-channel operating mode (IDLE when disabled, RUN when enabled)
package clk_div_pkg;

  localparam int unsigned MIN_DIV    = 2;
  localparam int unsigned DFLT_DIV   = 2;
  localparam int unsigned DFLT_DIV_W = 16;

  typedef logic [DFLT_DIV_W-1:0] div_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active divisor, phase counter, one-deep pending
// divisor register and registered clk_out / tick outputs.
//   clk_in   system clock
//   rst_n    synchronous reset, active-low
//   en       run enable (0 = IDLE, 1 = RUN)
//   sync     realign phase: counter to 0, outputs low, pending applied
//   wr       accepted divisor write for this channel (only when pend=0)
//   wr_div   divisor to store (values below MIN_DIV are clamped)
//   pend     a written divisor is waiting to be applied
//   clk_out  divided clock, high for ceil(div/2) of each div-cycle period
//   tick     high for the last cycle of each period
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = DFLT_DIV_W,
  parameter int unsigned DEF_DIV = DFLT_DIV
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] wr_div_cl;
  logic [DIV_W:0]   hi;
  logic             wrap;
  ch_mode_e         mode;

  assign mode      = en ? CH_RUN : CH_IDLE;
  // One extra bit so div_act = 2**DIV_W-1 does not overflow on the +1.
  assign hi        = ({1'b0, div_act} + (DIV_W+1)'(1)) >> 1;
  assign wrap      = (cnt == div_act - DIV_W'(1));
  assign wr_div_cl = (wr_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : wr_div;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= DIV_W'(DEF_DIV);
      pend_div <= DIV_W'(DEF_DIV);
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      // wr is only ever asserted while pend is clear, so a store and an
      // apply never happen on the same edge.
      if (wr) begin
        pend_div <= wr_div_cl;
        pend     <= 1'b1;
      end
      case (mode)
        CH_IDLE: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
          if (pend) begin
            div_act <= pend_div;
            pend    <= 1'b0;
          end
        end
        CH_RUN: begin
          if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            if (pend) begin
              div_act <= pend_div;
              pend    <= 1'b0;
            end
          end else begin
            clk_out <= ({1'b0, cnt} < hi);
            tick    <= wrap;
            cnt     <= wrap ? '0 : cnt + DIV_W'(1);
            if (wrap && pend) begin
              div_act <= pend_div;
              pend    <= 1'b0;
            end
          end
        end
        default: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent, runtime-programmable integer clock dividers.
//   clk_in     system clock
//   rst_n      synchronous reset, active-low
//   cfg_valid  divisor write request
//   cfg_ready  channel cfg_ch can accept a write (combinational)
//   cfg_ch     target channel of the write
//   cfg_div    new divisor (values below 2 are stored as 2)
//   sync       one-cycle pulse realigning the phase of every channel
//   en         per-channel run enable
//   clk_out    per-channel divided clock, registered
//   tick       per-channel one-cycle pulse on the last cycle of each period
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int unsigned N_CH    = 2,
  parameter  int unsigned DIV_W   = DFLT_DIV_W,
  parameter  int unsigned DEF_DIV = DFLT_DIV,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             sync,
  input  logic [N_CH-1:0]  en,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;

  // A channel index beyond N_CH never reports ready, so it is never written.
  always_comb begin
    cfg_ready = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .pend    (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule
